// File: rtl/pic_pkg.sv
// Shared types and bit positions for the 8259-style bus interface.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package pic_pkg;

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } pic_state_t;

    // Command strobe bundle, one bit per ICW/OCW register write
    typedef struct packed {
        logic icw_1;
        logic icw_2;
        logic icw_3;
        logic icw_4;
        logic ocw_1;
        logic ocw_2;
        logic ocw_3;
    } pic_cmd_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_D3    = 3;
    localparam int CMD_D4    = 4;

endpackage

// File: rtl/pic_strobe_sync.sv
// Multi-flop synchroniser for an active-low asynchronous CPU strobe; resets to inactive (1).
// Latency: SYNC_STAGES clock edges from pin to sync_n.
// Backpressure: none; it samples every cycle.
module pic_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic pin_n,
    output logic sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_n};
        end
    end

    assign sync_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pic_bus_interface.sv
// CPU-side bus interface of the PIC: it synchronises the strobes, captures writes, decodes ICW/OCW and drives reads.
// Latency: a command strobe follows SYNC_STAGES+1 edges after the WR rising edge; a read follows SYNC_STAGES+1 edges after RD falls.
// Backpressure: none; the CPU must hold WR high for one synchronised cycle between writes.
module pic_bus_interface
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  address,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    input  logic [DATA_WIDTH-1:0] core_read_data,
    output logic [DATA_WIDTH-1:0] data_bus_out,
    output logic                  data_bus_oe,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_icw_1,
    output logic                  write_icw_2,
    output logic                  write_icw_3,
    output logic                  write_icw_4,
    output logic                  write_ocw_1,
    output logic                  write_ocw_2,
    output logic                  write_ocw_3,
    output logic                  read,
    output logic                  init_done
);

    logic cs_s, rd_s, wr_s;
    logic cs_prev, wr_prev;
    logic hold_vld, hold_a0;
    logic [DATA_WIDTH-1:0] hold_dat;
    logic sngl, ic4;
    pic_state_t state, state_nxt;
    pic_cmd_t   cmd, cmd_nxt;

    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clock(clock), .reset_n(reset_n), .pin_n(chip_select_n), .sync_n(cs_s));
    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .clock(clock), .reset_n(reset_n), .pin_n(read_enable_n), .sync_n(rd_s));
    pic_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clock(clock), .reset_n(reset_n), .pin_n(write_enable_n), .sync_n(wr_s));

    // RD and WR low together is illegal: it blocks both capture and read drive
    wire legal_wr = !cs_s && !wr_s && rd_s;
    wire rd_act   = !cs_s && !rd_s && wr_s;
    wire commit   = wr_s && !wr_prev && !cs_prev && hold_vld;
    wire icw1_hit = commit && !hold_a0 && hold_dat[CMD_D4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNINIT;
            sngl  <= 1'b1;
            ic4   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (icw1_hit) begin
                sngl <= hold_dat[ICW1_SNGL];
                ic4  <= hold_dat[ICW1_IC4];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = '0;
        if (icw1_hit) begin
            cmd_nxt.icw_1 = 1'b1;
            state_nxt     = WAIT_ICW2;
        end else if (commit && !hold_a0) begin
            if (state == READY) begin
                cmd_nxt.ocw_3 = hold_dat[CMD_D3];
                cmd_nxt.ocw_2 = !hold_dat[CMD_D3];
            end
        end else if (commit) begin
            case (state)
                WAIT_ICW2: begin
                    cmd_nxt.icw_2 = 1'b1;
                    state_nxt = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
                end
                WAIT_ICW3: begin
                    cmd_nxt.icw_3 = 1'b1;
                    state_nxt = ic4 ? WAIT_ICW4 : READY;
                end
                WAIT_ICW4: begin
                    cmd_nxt.icw_4 = 1'b1;
                    state_nxt = READY;
                end
                READY:   cmd_nxt.ocw_1 = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_prev           <= 1'b1;
            wr_prev           <= 1'b1;
            hold_vld          <= 1'b0;
            hold_a0           <= 1'b0;
            hold_dat          <= '0;
            internal_data_bus <= '0;
            data_bus_out      <= '0;
            data_bus_oe       <= 1'b0;
            read              <= 1'b0;
            init_done         <= 1'b0;
            cmd               <= '0;
        end else begin
            cs_prev <= cs_s;
            wr_prev <= wr_s;
            if (legal_wr) begin
                hold_vld <= 1'b1;
                hold_a0  <= address;
                hold_dat <= data_bus_in;
            end else if (commit || cs_s) begin
                hold_vld <= 1'b0;
            end
            if (commit) begin
                internal_data_bus <= hold_dat;
            end
            data_bus_oe <= rd_act;
            if (rd_act) begin
                data_bus_out <= core_read_data;
            end
            read      <= rd_act && !data_bus_oe;
            init_done <= (state_nxt == READY);
            cmd       <= cmd_nxt;
        end
    end

    assign write_icw_1 = cmd.icw_1;
    assign write_icw_2 = cmd.icw_2;
    assign write_icw_3 = cmd.icw_3;
    assign write_icw_4 = cmd.icw_4;
    assign write_ocw_1 = cmd.ocw_1;
    assign write_ocw_2 = cmd.ocw_2;
    assign write_ocw_3 = cmd.ocw_3;

endmodule

// File: tb/tb_pic_bus_interface.sv
// Directed bench for pic_bus_interface: ICW sequences, OCW decode, reads, illegal RD/WR overlap, reset, latency.
// A second instance with SYNC_STAGES=3 shares the stimulus and is used for the latency check.
module tb_pic_bus_interface;

    logic       clock          = 1'b0;
    logic       reset_n        = 1'b0;
    logic       chip_select_n  = 1'b1;
    logic       read_enable_n  = 1'b1;
    logic       write_enable_n = 1'b1;
    logic       address        = 1'b0;
    logic [7:0] data_bus_in    = 8'h00;
    logic [7:0] core_read_data = 8'h00;

    logic [7:0] data_bus_out, internal_data_bus;
    logic       data_bus_oe, read, init_done;
    logic       write_icw_1, write_icw_2, write_icw_3, write_icw_4;
    logic       write_ocw_1, write_ocw_2, write_ocw_3;

    logic [7:0] b_data_bus_out, b_internal_data_bus;
    logic       b_data_bus_oe, b_read, b_init_done;
    logic       b_icw_1, b_icw_2, b_icw_3, b_icw_4, b_ocw_1, b_ocw_2, b_ocw_3;

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] vec;
    int         cnt, lat_a, lat_b, oe_cnt;
    logic       idn;
    logic [7:0] idb, dbo_seen;

    always #5 clock = ~clock;

    pic_bus_interface u_dut (
        .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
        .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
        .address(address), .data_bus_in(data_bus_in), .core_read_data(core_read_data),
        .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
        .internal_data_bus(internal_data_bus),
        .write_icw_1(write_icw_1), .write_icw_2(write_icw_2),
        .write_icw_3(write_icw_3), .write_icw_4(write_icw_4),
        .write_ocw_1(write_ocw_1), .write_ocw_2(write_ocw_2), .write_ocw_3(write_ocw_3),
        .read(read), .init_done(init_done));

    pic_bus_interface #(.DATA_WIDTH(8), .SYNC_STAGES(3)) u_dut_s3 (
        .clock(clock), .reset_n(reset_n), .chip_select_n(chip_select_n),
        .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
        .address(address), .data_bus_in(data_bus_in), .core_read_data(core_read_data),
        .data_bus_out(b_data_bus_out), .data_bus_oe(b_data_bus_oe),
        .internal_data_bus(b_internal_data_bus),
        .write_icw_1(b_icw_1), .write_icw_2(b_icw_2),
        .write_icw_3(b_icw_3), .write_icw_4(b_icw_4),
        .write_ocw_1(b_ocw_1), .write_ocw_2(b_ocw_2), .write_ocw_3(b_ocw_3),
        .read(b_read), .init_done(b_init_done));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Observe n cycles (#1 after each rising edge); optionally release CS/RD at given cycles
    task automatic sample_win(input int n, input int cs_up_at, input int rd_up_at);
        logic [7:0] s;
        logic [6:0] sb;
        vec = 0; cnt = 0; lat_a = 0; lat_b = 0; oe_cnt = 0;
        idn = 0; idb = 0; dbo_seen = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clock);
            #1;
            s  = {read, write_ocw_3, write_ocw_2, write_ocw_1,
                  write_icw_4, write_icw_3, write_icw_2, write_icw_1};
            sb = {b_ocw_3, b_ocw_2, b_ocw_1, b_icw_4, b_icw_3, b_icw_2, b_icw_1};
            if (s != 0) begin
                vec |= s;
                cnt += $countones(s);
                if (lat_a == 0) begin
                    lat_a = i;
                    idn   = init_done;
                    idb   = internal_data_bus;
                end
            end
            if (sb != 0 && lat_b == 0) lat_b = i;
            if (data_bus_oe) begin
                if (oe_cnt == 0) dbo_seen = data_bus_out;
                oe_cnt++;
            end
            if (i == cs_up_at) chip_select_n = 1'b1;
            if (i == rd_up_at) read_enable_n = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d);
        address        = a0;
        data_bus_in    = d;
        chip_select_n  = 1'b0;
        write_enable_n = 1'b0;
        repeat (4) @(negedge clock);
        write_enable_n = 1'b1;
        sample_win(10, 2, 0);
    endtask

    // exp_vec: bit0 icw1 .. bit3 icw4, bit4 ocw1, bit5 ocw2, bit6 ocw3, bit7 read
    task automatic wr_exp(input string tag, input logic a0, input logic [7:0] d,
                          input logic [7:0] exp_vec, input logic exp_idn);
        do_write(a0, d);
        chk({tag, " strobes"}, vec, exp_vec);
        chk({tag, " pulses"}, cnt, (exp_vec != 0) ? 1 : 0);
        if (exp_vec != 0) begin
            chk({tag, " latency"}, lat_a, 3);
            chk({tag, " init_done"}, idn, exp_idn);
            chk({tag, " int_bus"}, idb, d);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst oe", data_bus_oe, 0);
        chk("rst init_done", init_done, 0);
        chk("rst int_bus", internal_data_bus, 0);
        chk("rst dbo", data_bus_out, 0);
        chk("rst strobes", {read, write_ocw_3, write_ocw_2, write_ocw_1,
                            write_icw_4, write_icw_3, write_icw_2, write_icw_1}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        wr_exp("pre ocw2", 1'b0, 8'h20, 8'h00, 1'b0);
        wr_exp("pre ocw3", 1'b0, 8'h0B, 8'h00, 1'b0);
        wr_exp("pre a0", 1'b1, 8'hFF, 8'h00, 1'b0);

        wr_exp("t1 icw1", 1'b0, 8'h13, 8'h01, 1'b0);
        wr_exp("t1 icw2", 1'b1, 8'h20, 8'h02, 1'b0);
        wr_exp("t1 icw4", 1'b1, 8'h01, 8'h08, 1'b1);

        wr_exp("t2 icw1", 1'b0, 8'h10, 8'h01, 1'b0);
        wr_exp("t2 icw2", 1'b1, 8'h08, 8'h02, 1'b0);
        wr_exp("t2 icw3", 1'b1, 8'h04, 8'h04, 1'b1);
        wr_exp("t2 ocw1", 1'b1, 8'hFF, 8'h10, 1'b1);

        wr_exp("t3 ocw2", 1'b0, 8'h20, 8'h20, 1'b1);
        wr_exp("t3 ocw3", 1'b0, 8'h0B, 8'h40, 1'b1);

        core_read_data = 8'hA5;
        chip_select_n  = 1'b0;
        read_enable_n  = 1'b0;
        sample_win(12, 5, 5);
        chk("t4 oe cycles", oe_cnt, 5);
        chk("t4 strobes", vec, 8'h80);
        chk("t4 read pulses", cnt, 1);
        chk("t4 read latency", lat_a, 3);
        chk("t4 dbo", dbo_seen, 8'hA5);
        chk("t4 oe released", data_bus_oe, 0);

        address        = 1'b0;
        data_bus_in    = 8'h0B;
        chip_select_n  = 1'b0;
        write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
        read_enable_n = 1'b0;
        sample_win(5, 0, 0);
        chk("t4 overlap oe", oe_cnt, 0);
        chk("t4 overlap strobes", vec, 8'h00);
        data_bus_in    = 8'h55;
        read_enable_n  = 1'b1;
        write_enable_n = 1'b1;
        sample_win(10, 2, 0);
        chk("t4 held strobes", vec, 8'h40);
        chk("t4 held pulses", cnt, 1);
        chk("t4 held int_bus", idb, 8'h0B);
        chk("t4 held oe", oe_cnt, 0);

        wr_exp("t5 icw1", 1'b0, 8'h10, 8'h01, 1'b0);
        wr_exp("t5 icw2", 1'b1, 8'h08, 8'h02, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5 rst init_done", init_done, 0);
        chk("t5 rst int_bus", internal_data_bus, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        wr_exp("t5 a0 uninit", 1'b1, 8'h04, 8'h00, 1'b0);
        wr_exp("t5 icw1 again", 1'b0, 8'h12, 8'h01, 1'b0);
        wr_exp("t5 icw2 ready", 1'b1, 8'h30, 8'h02, 1'b1);

        wr_exp("t6 icw1", 1'b0, 8'h13, 8'h01, 1'b0);
        chk("t6 s3 latency", lat_b, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
